// File: rtl/proc_status_reg_if.sv
// 6502 status-register bundle: ALU results and microcode flag controls in, P images out.
// Latency: none; wires only.
// Backpressure: none; every control is sampled on every clock edge.
interface proc_status_reg_if;
  logic [7:0] alu_Y;
  logic       alu_carry_out;
  logic       alu_overflow;
  logic [7:0] data_in;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_op;
  logic [2:0] flag_op;
  logic       load_p;
  logic       irq_entry;
  logic       push_brk;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       carry_flag;
  logic       decimal_flag;
  logic       irq_disable;

  // Microcode / datapath side: drives the controls and consumes the flags.
  modport master (
    output alu_Y, alu_carry_out, alu_overflow, data_in,
    output upd_nz, upd_c, upd_v, bit_op, flag_op, load_p, irq_entry, push_brk,
    input  p_out, p_push, carry_flag, decimal_flag, irq_disable
  );

  // Status register side.
  modport slave (
    input  alu_Y, alu_carry_out, alu_overflow, data_in,
    input  upd_nz, upd_c, upd_v, bit_op, flag_op, load_p, irq_entry, push_brk,
    output p_out, p_push, carry_flag, decimal_flag, irq_disable
  );
endinterface

// File: rtl/proc_status_reg.sv
// 6502 processor status register P: six flag flops (N,V,D,I,Z,C) updated by ALU/microcode.
// Latency: flag updates visible one cycle after the controlling edge; p_push tracks push_brk combinationally.
// Backpressure: none; controls are acted on every cycle they are asserted.
module proc_status_reg (
  input  logic               clk,
  input  logic               reset,
  proc_status_reg_if.slave   bus
);

  localparam logic [2:0] FOP_CLC = 3'd1;
  localparam logic [2:0] FOP_SEC = 3'd2;
  localparam logic [2:0] FOP_CLI = 3'd3;
  localparam logic [2:0] FOP_SEI = 3'd4;
  localparam logic [2:0] FOP_CLV = 3'd5;
  localparam logic [2:0] FOP_CLD = 3'd6;
  localparam logic [2:0] FOP_SED = 3'd7;

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic alu_zero;

  assign alu_zero = (bus.alu_Y == 8'h00);

  // Per-flag next state; load_p beats everything, then irq_entry (I only),
  // explicit flag ops, BIT, and finally the plain ALU update strobes.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (bus.load_p) begin
      n_d = bus.data_in[7];
      v_d = bus.data_in[6];
      d_d = bus.data_in[3];
      i_d = bus.data_in[2];
      z_d = bus.data_in[1];
      c_d = bus.data_in[0];
    end else begin
      // N and Z: BIT takes N from memory but Z from the AND result on alu_Y.
      if (bus.bit_op) begin
        n_d = bus.data_in[7];
        z_d = alu_zero;
      end else if (bus.upd_nz) begin
        n_d = bus.alu_Y[7];
        z_d = alu_zero;
      end

      // V
      if (bus.flag_op == FOP_CLV) begin
        v_d = 1'b0;
      end else if (bus.bit_op) begin
        v_d = bus.data_in[6];
      end else if (bus.upd_v) begin
        v_d = bus.alu_overflow;
      end

      // C
      if (bus.flag_op == FOP_SEC) begin
        c_d = 1'b1;
      end else if (bus.flag_op == FOP_CLC) begin
        c_d = 1'b0;
      end else if (bus.upd_c) begin
        c_d = bus.alu_carry_out;
      end

      // D
      if (bus.flag_op == FOP_SED) begin
        d_d = 1'b1;
      end else if (bus.flag_op == FOP_CLD) begin
        d_d = 1'b0;
      end

      // I: interrupt entry must win over a concurrent CLI.
      if (bus.irq_entry) begin
        i_d = 1'b1;
      end else if (bus.flag_op == FOP_SEI) begin
        i_d = 1'b1;
      end else if (bus.flag_op == FOP_CLI) begin
        i_d = 1'b0;
      end
    end
  end

  // Flag storage; reset clears all flags except I, which comes up set.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= 1'b0;
      v_q <= 1'b0;
      d_q <= 1'b0;
      i_q <= 1'b1;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign bus.p_out        = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign bus.p_push       = {n_q, v_q, 1'b1, bus.push_brk, d_q, i_q, z_q, c_q};
  assign bus.carry_flag   = c_q;
  assign bus.decimal_flag = d_q;
  assign bus.irq_disable  = i_q;

endmodule

// File: tb/tb_proc_status_reg.sv
// Directed bench for proc_status_reg with hand-computed expected flag images.
// Latency: checks sampled 1 time unit after the rising edge that applies a control.
// Backpressure: not applicable.
module tb_proc_status_reg;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_err;

  proc_status_reg_if bus ();

  proc_status_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_Y         = 8'h00;
    bus.alu_carry_out = 1'b0;
    bus.alu_overflow  = 1'b0;
    bus.data_in       = 8'h00;
    bus.upd_nz        = 1'b0;
    bus.upd_c         = 1'b0;
    bus.upd_v         = 1'b0;
    bus.bit_op        = 1'b0;
    bus.flag_op       = 3'd0;
    bus.load_p        = 1'b0;
    bus.irq_entry     = 1'b0;
    bus.push_brk      = 1'b0;
  endtask

  // Apply the currently driven controls for one edge, then clear them.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
  endtask

  task automatic do_flag(input logic [2:0] op);
    bus.flag_op = op;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    idle();
    reset = 1'b1;

    // Reset held two cycles with every update control active.
    bus.upd_nz = 1'b1; bus.upd_c = 1'b1; bus.upd_v = 1'b1; bus.load_p = 1'b1;
    bus.alu_Y = 8'h80; bus.alu_carry_out = 1'b1; bus.alu_overflow = 1'b1;
    bus.data_in = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    chk("reset_p_out", bus.p_out, 8'h34);
    chk("reset_irq_disable", {7'd0, bus.irq_disable}, 8'h01);
    chk("reset_carry", {7'd0, bus.carry_flag}, 8'h00);
    chk("reset_decimal", {7'd0, bus.decimal_flag}, 8'h00);
    chk("reset_push_b0", bus.p_push, 8'h24);
    bus.push_brk = 1'b1;
    #1;
    chk("reset_push_b1", bus.p_push, 8'h34);
    bus.push_brk = 1'b0;

    // ADD capture, then zero result with carry.
    bus.alu_Y = 8'hA0; bus.alu_carry_out = 1'b0; bus.alu_overflow = 1'b1;
    bus.upd_nz = 1'b1; bus.upd_c = 1'b1; bus.upd_v = 1'b1;
    step();
    chk("add_neg_ovf", bus.p_out, 8'hF4);
    bus.alu_Y = 8'h00; bus.alu_carry_out = 1'b1; bus.alu_overflow = 1'b0;
    bus.upd_nz = 1'b1; bus.upd_c = 1'b1; bus.upd_v = 1'b1;
    step();
    chk("add_zero_carry", bus.p_out, 8'h37);
    chk("add_carry_flag", {7'd0, bus.carry_flag}, 8'h01);

    // SR-style shift: carry from old bit 0, N from alu_Y[7]; V untouched.
    bus.alu_Y = 8'h80; bus.alu_carry_out = 1'b0; bus.upd_nz = 1'b1; bus.upd_c = 1'b1;
    step();
    chk("shift_nc", bus.p_out, 8'hB4);

    // PLP loads and push images.
    bus.load_p = 1'b1; bus.data_in = 8'hCF;
    step();
    chk("plp_cf", bus.p_out, 8'hFF);
    bus.load_p = 1'b1; bus.data_in = 8'h00;
    step();
    chk("plp_00", bus.p_out, 8'h30);
    chk("push_b0", bus.p_push, 8'h20);
    bus.push_brk = 1'b1;
    #1;
    chk("push_b1", bus.p_push, 8'h30);
    bus.push_brk = 1'b0;

    // Flag ops from reset.
    reset = 1'b1;
    step();
    do_flag(3'd2);
    chk("sec", bus.p_out, 8'h35);
    do_flag(3'd7);
    chk("sed", bus.p_out, 8'h3D);
    chk("sed_decimal", {7'd0, bus.decimal_flag}, 8'h01);
    do_flag(3'd3);
    chk("cli", bus.p_out, 8'h39);
    do_flag(3'd5);
    chk("clv", bus.p_out, 8'h39);
    do_flag(3'd1);
    chk("clc", bus.p_out, 8'h38);
    bus.flag_op = 3'd2; bus.upd_c = 1'b1; bus.alu_carry_out = 1'b0;
    step();
    chk("sec_beats_upd_c", bus.p_out, 8'h39);

    // BIT: N/V from data_in, Z from alu_Y, overriding upd_v/upd_nz.
    bus.bit_op = 1'b1; bus.data_in = 8'h40; bus.alu_Y = 8'h00;
    bus.upd_v = 1'b1; bus.alu_overflow = 1'b0;
    step();
    chk("bit_40", bus.p_out, 8'h7B);
    bus.bit_op = 1'b1; bus.data_in = 8'h80; bus.alu_Y = 8'h05; bus.upd_nz = 1'b1;
    step();
    chk("bit_80", bus.p_out, 8'hB9);

    // Interrupt collisions.
    bus.irq_entry = 1'b1; bus.flag_op = 3'd3;
    step();
    chk("irq_vs_cli", bus.p_out, 8'hBD);
    chk("irq_vs_cli_i", {7'd0, bus.irq_disable}, 8'h01);
    bus.load_p = 1'b1; bus.data_in = 8'h00; bus.irq_entry = 1'b1;
    step();
    chk("loadp_vs_irq", bus.p_out, 8'h30);
    bus.upd_v = 1'b1; bus.alu_overflow = 1'b1;
    step();
    chk("upd_v_only", bus.p_out, 8'h70);
    reset = 1'b1; bus.load_p = 1'b1; bus.data_in = 8'hFF;
    step();
    chk("reset_vs_loadp", bus.p_out, 8'h34);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
